hdr_ctrl: RTL and testbench
===========================

Name: hdr_ctrl

Overview:
Per-pixel sequencer for the HDR merge datapath. On a frame trigger it walks every pixel of the three stored exposures (high/mid/low, RGB565) through one shared read port and splits each word into the 5/6/5-bit colour fields. It drives the merge block's pixel inputs and single-cycle start pulse, then captures the three 12-bit log-radiance results on done. Results go out on a valid/ready stream with raster-position flags.

Parameters:
H_RES, 640, pixels per line
V_RES, 480, lines per frame
ADDR_W, 20, read address width
BASE_HIGH, 0, word address of pixel (0,0) of high exposure
BASE_MID, 307200, word address of pixel (0,0) of mid exposure
BASE_LOW, 614400, word address of pixel (0,0) of low exposure

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
frame_start  in  1  single-cycle pulse; begins one frame
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  single-cycle pulse after the last pixel is accepted downstream
rd_req  out  1  read request; held until rd_ack
rd_addr  out  ADDR_W  read word address; stable while rd_req
rd_ack  in  1  request accepted this cycle
rd_valid  in  1  read data valid (one cycle per accepted request)
rd_data  in  16  RGB565 word {R[15:11],G[10:5],B[4:0]}
red_high/red_mid/red_low  out  5 each  merge-block red inputs
green_high/green_mid/green_low  out  6 each  merge-block green inputs
blue_high/blue_mid/blue_low  out  5 each  merge-block blue inputs
hdr_start  out  1  single-cycle start pulse to merge block
lE_red/lE_green/lE_blue  in  12 each  merge-block results
hdr_done  in  1  merge-block result-valid pulse
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  36  {lE_red, lE_green, lE_blue}
out_sol  out  1  result is x==0
out_eol  out  1  result is x==H_RES-1
out_sof  out  1  result is (0,0)
out_eof  out  1  result is (H_RES-1,V_RES-1)

Behaviour:
- Reset (async assert, sync release): state IDLE, x=y=0; busy, frame_done, rd_req, hdr_start, out_valid, all sof/eof/sol/eol = 0; rd_addr, out_data and all colour outputs = 0. Reset mid-frame abandons the frame; no frame_done.
- States: IDLE, REQ_H, DAT_H, REQ_M, DAT_M, REQ_L, DAT_L, START, WAIT, OUT.
- IDLE: frame_start -> REQ_H, busy=1, x=y=0. frame_start while busy is ignored.
- REQ_e: rd_req=1, rd_addr=BASE_e + y*H_RES + x (precomputed index register, incremented per pixel, no multiplier). rd_ack -> DAT_e, rd_req drops next cycle. One outstanding read; order is high, mid, low.
- DAT_e: on rd_valid register split fields into the e outputs; H->REQ_M, M->REQ_L, L->START. Read latency is unbounded; no timeout.
- START: hdr_start=1 for exactly one cycle -> WAIT. Colour outputs are held stable from START until hdr_done is seen.
- WAIT: hdr_done -> register lE_* into out_data, set position flags, out_valid=1 -> OUT. Nominal merge latency is 3 cycles after hdr_start; the controller relies only on hdr_done.
- OUT: hold out_valid/out_data/flags stable until out_ready. On handshake out_valid=0 next cycle. If not last pixel: advance x (wrap to 0 at H_RES-1 and increment y) -> REQ_H. If last: frame_done=1 one cycle, busy=0 -> IDLE.
- Ignored inputs: rd_ack outside REQ_*, rd_valid outside DAT_*, and hdr_done outside WAIT.
- Throughput: one pixel at a time, no overlap. Minimum cost per pixel = 3*(ack+data) + START + 3 + 1 handshake cycles.
- Widths: pixel index is ceil(log2(H_RES*V_RES)) bits. Address sum truncates to ADDR_W; parameters must fit.

Test Plan:
- H_RES=4,V_RES=2, zero-latency memory (ack same cycle, valid next), out_ready=1, frame_start -> 8 results in raster order. Reads go to addr 0,8,16 for pixel 0 and 7,15,23 for pixel 7. Exactly 8 hdr_start pulses, one frame_done, busy low after.
- Memory word high=0xF800, mid=0x07E0, low=0x001F -> red_high=31, green_mid=63, blue_low=31, all other fields 0, stable until hdr_done.
- Model hdr_done 3 cycles after hdr_start with lE_red=0x123, lE_green=0x456, lE_blue=0x789 -> out_data=0x123456789. Pixel 0 has out_sof=out_sol=1. Pixel 3 has out_eol=1. Pixel 7 has out_eof=out_eol=1.
- out_ready low for 10 cycles on pixel 2 -> out_valid and out_data held; no rd_req or hdr_start during stall; resumes with pixel 3.
- Random rd_ack delay 0-5 cycles, rd_valid delay 1-7 cycles -> rd_addr stable while rd_req; results identical to the zero-latency run.
- Assert rst_n low during WAIT of pixel 5 -> all outputs zero immediately, no frame_done. A new frame_start after release restarts at addr 0.

Source files
------------

// File: rtl/hdr_ctrl.sv
// hdr_ctrl: walks each pixel of three stored exposures through one read port,
// feeds the merge block and streams its log-radiance results with raster flags.
module hdr_ctrl #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 20,
    parameter int BASE_HIGH = 0,
    parameter int BASE_MID  = 307200,
    parameter int BASE_LOW  = 614400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic [4:0]        red_high,
    output logic [4:0]        red_mid,
    output logic [4:0]        red_low,
    output logic [5:0]        green_high,
    output logic [5:0]        green_mid,
    output logic [5:0]        green_low,
    output logic [4:0]        blue_high,
    output logic [4:0]        blue_mid,
    output logic [4:0]        blue_low,
    output logic              hdr_start,
    input  logic [11:0]       lE_red,
    input  logic [11:0]       lE_green,
    input  logic [11:0]       lE_blue,
    input  logic              hdr_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [35:0]       out_data,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_sof,
    output logic              out_eof
);
    localparam int PIX   = H_RES * V_RES;
    localparam int IDX_W = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [3:0] {
        IDLE, REQ_H, DAT_H, REQ_M, DAT_M, REQ_L, DAT_L, START, WAIT, OUT
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [15:0]        hi_q, hi_d, mid_q, mid_d, lo_q, lo_d;
    logic               hdr_start_q, hdr_start_d;
    logic               out_valid_q, out_valid_d;
    logic [35:0]        out_data_q, out_data_d;
    logic               sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
    logic               last;

    // Linear pixel index replaces y*H_RES+x, so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] addr_of(input int base, input logic [IDX_W-1:0] i);
        return ADDR_W'(base) + ADDR_W'(i);
    endfunction

    assign last = idx_q == IDX_W'(PIX - 1);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        hi_d         = hi_q;
        mid_d        = mid_q;
        lo_d         = lo_q;
        hdr_start_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        sol_d        = sol_q;
        eol_d        = eol_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        unique case (state_q)
            IDLE: if (frame_start) begin
                state_d   = REQ_H;
                busy_d    = 1'b1;
                x_d       = '0;
                y_d       = '0;
                idx_d     = '0;
                rd_req_d  = 1'b1;
                rd_addr_d = addr_of(BASE_HIGH, '0);
            end
            REQ_H, REQ_M, REQ_L: if (rd_ack) begin
                rd_req_d = 1'b0;
                state_d  = (state_q == REQ_H) ? DAT_H : (state_q == REQ_M) ? DAT_M : DAT_L;
            end
            DAT_H: if (rd_valid) begin
                hi_d      = rd_data;
                state_d   = REQ_M;
                rd_req_d  = 1'b1;
                rd_addr_d = addr_of(BASE_MID, idx_q);
            end
            DAT_M: if (rd_valid) begin
                mid_d     = rd_data;
                state_d   = REQ_L;
                rd_req_d  = 1'b1;
                rd_addr_d = addr_of(BASE_LOW, idx_q);
            end
            DAT_L: if (rd_valid) begin
                lo_d        = rd_data;
                state_d     = START;
                hdr_start_d = 1'b1;
            end
            START: state_d = WAIT;
            WAIT: if (hdr_done) begin
                out_data_d  = {lE_red, lE_green, lE_blue};
                sol_d       = x_q == '0;
                eol_d       = x_q == X_W'(H_RES - 1);
                sof_d       = (x_q == '0) && (y_q == '0);
                eof_d       = last;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                if (last) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    x_d       = eol_q ? '0 : x_q + 1'b1;
                    y_d       = eol_q ? y_q + 1'b1 : y_q;
                    idx_d     = idx_q + 1'b1;
                    state_d   = REQ_H;
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_of(BASE_HIGH, idx_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            hi_q         <= '0;
            mid_q        <= '0;
            lo_q         <= '0;
            hdr_start_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sol_q        <= 1'b0;
            eol_q        <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            hi_q         <= hi_d;
            mid_q        <= mid_d;
            lo_q         <= lo_d;
            hdr_start_q  <= hdr_start_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sol_q        <= sol_d;
            eol_q        <= eol_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign hdr_start  = hdr_start_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sol    = sol_q;
    assign out_eol    = eol_q;
    assign out_sof    = sof_q;
    assign out_eof    = eof_q;
    assign {red_high, green_high, blue_high} = hi_q;
    assign {red_mid, green_mid, blue_mid}    = mid_q;
    assign {red_low, green_low, blue_low}    = lo_q;
endmodule

// File: tb/tb_hdr_ctrl.sv
// tb_hdr_ctrl: randomized memory/merge responders with a pixel-level reference
// model of addresses, colour fields and streamed results.
module tb_hdr_ctrl;
    localparam int H = 4, V = 2, PIX = H * V, BH = 0, BM = 8, BL = 16;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, busy, frame_done, rd_req, rd_ack, rd_valid;
    logic [19:0] rd_addr;
    logic [15:0] rd_data;
    logic [4:0]  red_high, red_mid, red_low, blue_high, blue_mid, blue_low;
    logic [5:0]  green_high, green_mid, green_low;
    logic        hdr_start, hdr_done, out_valid, out_ready;
    logic [11:0] lE_red, lE_green, lE_blue;
    logic [35:0] out_data;
    logic        out_sol, out_eol, out_sof, out_eof;

    logic [15:0] mem [32];
    logic [35:0] le [PIX];
    logic [19:0] addr_log [$];
    logic [47:0] col_log [$];
    logic [39:0] res_log [$];
    int          nstart_tot = 0, ndone = 0, nacc = 0, addr_bad = 0, col_bad = 0, out_bad = 0;
    int          nvec = 0, nerr = 0;
    bit          lat = 1'b0;

    logic [47:0] cols, snap;
    logic [39:0] res_now, hold;
    logic [19:0] ra;
    int          dly, ns;
    logic        stall_prev;

    assign cols    = {red_high, green_high, blue_high, red_mid, green_mid, blue_mid,
                      red_low, green_low, blue_low};
    assign res_now = {out_sof, out_eof, out_sol, out_eol, out_data};

    always #5 clk = ~clk;

    hdr_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(20), .BASE_HIGH(BH), .BASE_MID(BM), .BASE_LOW(BL)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .red_high(red_high), .red_mid(red_mid), .red_low(red_low),
        .green_high(green_high), .green_mid(green_mid), .green_low(green_low),
        .blue_high(blue_high), .blue_mid(blue_mid), .blue_low(blue_low),
        .hdr_start(hdr_start), .lE_red(lE_red), .lE_green(lE_green), .lE_blue(lE_blue),
        .hdr_done(hdr_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof)
    );

    function automatic int base_of(input int e);
        return (e == 0) ? BH : (e == 1) ? BM : BL;
    endfunction

    function automatic logic [39:0] exp_res(input int p);
        return {p == 0, p == PIX - 1, p % H == 0, p % H == H - 1, le[p]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: optional ack/data delays, junk rd_valid while waiting for ack, junk rd_ack while data is pending.
    initial begin : mem_model
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        @(negedge clk);
        forever begin
            if (rd_req) begin
                ra  = rd_addr;
                dly = lat ? int'($urandom_range(0, 5)) : 0;
                repeat (dly) begin
                    rd_valid = 1'($urandom_range(0, 1)); rd_data = 16'($urandom);
                    @(negedge clk);
                    if (!rd_req || rd_addr !== ra) addr_bad++;
                end
                rd_valid = 1'b0; rd_ack = 1'b1; addr_log.push_back(ra);
                @(negedge clk);
                rd_ack = 1'b0;
                dly = lat ? int'($urandom_range(1, 7)) : 1;
                repeat (dly - 1) begin rd_ack = 1'($urandom_range(0, 1)); @(negedge clk); end
                rd_ack = 1'b0; rd_valid = 1'b1; rd_data = mem[ra[4:0]];
                @(negedge clk);
                rd_valid = 1'b0; rd_data = 16'($urandom);
            end else @(negedge clk);
        end
    end

    // Merge block: result 3 cycles after hdr_start, junk lE values outside the done pulse.
    initial begin : merge_model
        hdr_done = 1'b0; {lE_red, lE_green, lE_blue} = '0; ns = 0;
        forever begin
            @(negedge clk);
            if (!busy) ns = 0;
            if (hdr_start) begin
                snap = cols; col_log.push_back(cols); nstart_tot++;
                {lE_red, lE_green, lE_blue} = 36'({$urandom, $urandom});
                repeat (3) begin @(negedge clk); if (rst_n && cols !== snap) col_bad++; end
                hdr_done = 1'b1; {lE_red, lE_green, lE_blue} = le[ns % PIX]; ns++;
                @(negedge clk);
                if (rst_n && cols !== snap) col_bad++;
                hdr_done = 1'b0; {lE_red, lE_green, lE_blue} = 36'({$urandom, $urandom});
            end
        end
    end

    initial begin : out_monitor
        stall_prev = 1'b0; hold = '0;
        forever begin
            @(negedge clk);
            if (frame_done) ndone++;
            if (stall_prev && (!out_valid || res_now !== hold)) out_bad++;
            if (out_valid && out_ready) begin res_log.push_back(res_now); nacc++; end
            stall_prev = out_valid && !out_ready;
            hold = res_now;
        end
    end

    task automatic start_frame;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic chk_zero(input string f);
        chk({f, "_busy"}, 64'(busy), 64'(0));
        chk({f, "_frame_done"}, 64'(frame_done), 64'(0));
        chk({f, "_rd_req"}, 64'(rd_req), 64'(0));
        chk({f, "_rd_addr"}, 64'(rd_addr), 64'(0));
        chk({f, "_hdr_start"}, 64'(hdr_start), 64'(0));
        chk({f, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({f, "_out_data"}, 64'(out_data), 64'(0));
        chk({f, "_flags"}, 64'({out_sof, out_eof, out_sol, out_eol}), 64'(0));
        chk({f, "_colours"}, 64'(cols), 64'(0));
    endtask

    task automatic check_frame(input string f, input int ab, input int cb, input int rb, input int d0, input int s0);
        int i;
        i = 0;
        while (ndone == d0 && i < 4000) begin @(negedge clk); i++; end
        chk({f, "_done_seen"}, 64'(ndone > d0), 64'(1));
        repeat (20) @(negedge clk);
        chk({f, "_done_cnt"}, 64'(ndone - d0), 64'(1));
        chk({f, "_busy_after"}, 64'(busy), 64'(0));
        chk({f, "_starts"}, 64'(nstart_tot - s0), 64'(PIX));
        chk({f, "_nreads"}, 64'(addr_log.size() - ab), 64'(3 * PIX));
        chk({f, "_nres"}, 64'(res_log.size() - rb), 64'(PIX));
        for (int p = 0; p < PIX; p++) begin
            for (int e = 0; e < 3; e++)
                if (ab + 3 * p + e < addr_log.size())
                    chk($sformatf("%s_addr_p%0d_e%0d", f, p, e), 64'(addr_log[ab + 3 * p + e]), 64'(base_of(e) + p));
            if (cb + p < col_log.size())
                chk($sformatf("%s_colours_p%0d", f, p), 64'(col_log[cb + p]), 64'({mem[BH + p], mem[BM + p], mem[BL + p]}));
            if (rb + p < res_log.size())
                chk($sformatf("%s_result_p%0d", f, p), 64'(res_log[rb + p]), 64'(exp_res(p)));
        end
    endtask

    initial begin : main
        int ab, cb, rb, d0, s0, a0, quiet;
        logic [35:0] held;
        bit found;
        rst_n = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[BH] = 16'hF800; mem[BM] = 16'h07E0; mem[BL] = 16'h001F;
        for (int p = 0; p < PIX; p++) le[p] = 36'({$urandom, $urandom});
        le[0] = 36'h123456789;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-latency frame, with a frame_start pulse mid-frame that must be ignored.
        ab = addr_log.size(); cb = col_log.size(); rb = res_log.size(); d0 = ndone; s0 = nstart_tot;
        start_frame();
        chk("f1_busy_start", 64'(busy), 64'(1));
        repeat (30) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        check_frame("f1", ab, cb, rb, d0, s0);
        if (cb < col_log.size()) begin
            chk("p0_red_high", 64'(col_log[cb][47:43]), 64'(31));
            chk("p0_green_mid", 64'(col_log[cb][26:21]), 64'(63));
            chk("p0_blue_low", 64'(col_log[cb][4:0]), 64'(31));
        end
        if (rb < res_log.size()) chk("p0_out_data", 64'(res_log[rb][35:0]), 64'(36'h123456789));
        chk("f1_no_restart", 64'(addr_log.size() - ab), 64'(3 * PIX));

        // Random latencies plus a 10-cycle downstream stall on pixel 2.
        lat = 1'b1;
        ab = addr_log.size(); cb = col_log.size(); rb = res_log.size(); d0 = ndone; s0 = nstart_tot; a0 = nacc;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk); #1;
            found = out_valid && (nacc - a0 == 2);
        end
        chk("stall_reach", 64'(found), 64'(1));
        out_ready = 1'b0; held = out_data; quiet = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rd_req || hdr_start || !out_valid || out_data !== held) quiet++;
        end
        chk("stall_quiet", 64'(quiet), 64'(0));
        out_ready = 1'b1;
        check_frame("f2", ab, cb, rb, d0, s0);
        lat = 1'b0;

        // Reset while the controller waits on pixel 5's merge result.
        d0 = ndone; s0 = nstart_tot;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk); #1;
            found = (nstart_tot - s0 == 6);
        end
        chk("rst_reach_wait", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 64'(ndone - d0), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        ab = addr_log.size(); cb = col_log.size(); rb = res_log.size(); d0 = ndone; s0 = nstart_tot;
        start_frame();
        check_frame("f4", ab, cb, rb, d0, s0);
        chk("restart_addr0", 64'(addr_log.size() > ab ? addr_log[ab] : 20'hFFFFF), 64'(BH));

        chk("addr_stable", 64'(addr_bad), 64'(0));
        chk("colour_stable", 64'(col_bad), 64'(0));
        chk("out_hold", 64'(out_bad), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
